cbus_writeback: RTL and testbench
=================================

Name: cbus_writeback

Overview:
- Producer side of the register C-bus write interface.
- Accepts write-back requests (destination register index plus 16-bit data) from the ALU, memory-read path and controller, and buffers them in a small FIFO.
- Drains one request per cycle as a registered C-bus word plus a one-hot register write-enable vector; each general-purpose register samples its enable and C-bus input on the same clock edge.

Parameters:
- DATA_W, 16, width of the C bus and of request data.
- NUM_REGS, 8, number of destination registers, i.e. width of the one-hot enable vector.
- IDX_W, 3, width of the destination index; must satisfy 2**IDX_W >= NUM_REGS.
- DEPTH, 4, FIFO depth in entries; must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  FIFO can accept a request this cycle.
- req_dest  input  IDX_W  destination register index.
- req_data  input  DATA_W  data to write.
- stall  input  1  hold the drain; no C-bus write issues while high.
- flush  input  1  synchronous discard of all queued requests.
- c_out  output  DATA_W  C-bus data, registered.
- wr_en  output  NUM_REGS  one-hot register write enables, registered; all zero when idle.
- bad_dest  output  1  one-cycle pulse when an accepted request had req_dest >= NUM_REGS.
- count  output  IDX_W+1  current FIFO occupancy, 0..DEPTH.
- busy  output  1  high when count != 0 or any wr_en bit is high.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears the FIFO pointers and count, c_out, wr_en and bad_dest to 0.
  - Outputs hold their reset values while rst is high.
  - Reset mid-drain: the in-flight write is lost, wr_en drops to zero immediately, and no partial write occurs.
- Push:
  - req_ready = (count < DEPTH) and not flush. Purely combinational from registered count; it does not depend on a same-cycle pop.
  - On an edge with req_valid and req_ready high, the entry {req_dest, req_data} is written at the tail.
- Pop:
  - On an edge with count != 0, stall low and flush low, the head entry is removed.
  - c_out <= head data.
  - wr_en <= one-hot(head dest); this is the only edge that sets wr_en.
- Idle: on any edge without a pop, wr_en <= 0 and c_out holds its last value. Each write therefore appears as exactly one cycle of wr_en.
- Latency: a request accepted at edge N, with an empty FIFO and stall low, produces wr_en/c_out after edge N+1, valid for the cycle N+1..N+2. The target register captures it at edge N+2.
- Throughput: one write per cycle sustained while the FIFO is non-empty and stall is low.
- Simultaneous push and pop: both occur and count is unchanged. When full, push is refused even if a pop occurs in the same cycle.
- FIFO order: strictly first-in, first-out. Pointers wrap modulo DEPTH.
- Repeated destinations: consecutive requests to the same destination are each written in order; the last one wins.
- Bad destination:
  - A popped entry with dest >= NUM_REGS drives wr_en <= 0 and pulses bad_dest for one cycle.
  - c_out is still updated.
  - The entry consumes its drain slot.
- stall: freezes the head. Pushes continue until the FIFO is full.
- flush:
  - On an edge with flush high, count <= 0, the pointers reset, and wr_en <= 0.
  - Flush wins over a same-cycle push and pop; a write already registered on the bus completes its cycle.
- Counter: count is IDX_W+1 wide and never exceeds DEPTH or underflows.

Test Plan:
- Single write: after reset, push dest=2, data=16'hA5A5 -> after the next edge, wr_en=8'b0000_0100 and c_out=16'hA5A5 for exactly one cycle; then wr_en=0 and busy=0.
- Back-to-back: push dest=0..3 with data 16'h0010,0011,0012,0013 on consecutive cycles -> wr_en walks 0001,0010,0100,1000 on consecutive cycles with matching data; count never exceeds 1.
- Full/stall:
  - Stimulus: stall=1, push 5 requests.
  - Required: the first 4 are accepted; req_ready=0 at count=4 and the 5th is held.
  - Then release stall: 4 writes in FIFO order, and the 5th is accepted on the cycle count drops to 3.
- Bad destination (NUM_REGS=6): push dest=7, data=16'h1234 -> wr_en stays 0, bad_dest pulses one cycle, c_out=16'h1234; the following dest=1 write proceeds normally.
- Flush: stall=1, queue 3 entries, then pulse flush together with req_valid -> count=0, no wr_en ever asserted, and the same-cycle request is not accepted.
- Async reset mid-drain: with 3 entries draining, assert rst between edges -> wr_en, c_out and count go to 0 immediately; after release, no stale writes occur.

Source files
------------

// File: rtl/cbus_writeback_if.sv
// Register C-bus write-back interface: request handshake toward the write-back
// buffer and the registered C-bus data / one-hot enables toward the register file.
interface cbus_writeback_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
);
  logic                req_valid;
  logic                req_ready;
  logic [IDX_W-1:0]    req_dest;
  logic [DATA_W-1:0]   req_data;
  logic [DATA_W-1:0]   c_out;
  logic [NUM_REGS-1:0] wr_en;

  modport master (
    output req_valid, req_dest, req_data,
    input  req_ready, c_out, wr_en
  );

  modport slave (
    input  req_valid, req_dest, req_data,
    output req_ready, c_out, wr_en
  );
endinterface

// File: rtl/cbus_writeback.sv
// C-bus write-back producer: buffers {dest, data} requests in a small FIFO and
// drains one per cycle as a registered C-bus word plus one-hot register enables.
module cbus_writeback #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  cbus_writeback_if.slave  bus,
  input  logic             stall,
  input  logic             flush,
  output logic             bad_dest,
  output logic [IDX_W:0]   count,
  output logic             busy
);

  localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [IDX_W:0]      count_q, count_d;
  logic [DATA_W-1:0]   c_out_q, c_out_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic                bad_dest_q, bad_dest_d;

  logic   ready;
  logic   push;
  logic   pop;
  logic   dest_ok;
  entry_t head;

  // Ready looks only at registered occupancy, so a full FIFO refuses a push
  // even when the same edge pops.
  assign ready = (count_q < DEPTH_C) && !flush;

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    dest_ok  = int'(head.dest) < NUM_REGS;
    push     = bus.req_valid && ready;
    pop      = (count_q != '0) && !stall && !flush;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{dest: bus.req_dest, data: bus.req_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flush overrides any same-cycle push or pop.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    c_out_d    = pop ? head.data : c_out_q;
    bad_dest_d = pop && !dest_ok;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_en_d[i] = pop && (int'(head.dest) == i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      c_out_q    <= '0;
      wr_en_q    <= '0;
      bad_dest_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      c_out_q    <= c_out_d;
      wr_en_q    <= wr_en_d;
      bad_dest_q <= bad_dest_d;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only ever read
  // behind the reset pointers and count, and omitting reset keeps it plain RAM.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.req_ready = ready;
  assign bus.c_out     = c_out_q;
  assign bus.wr_en     = wr_en_q;
  assign bad_dest      = bad_dest_q;
  assign count         = count_q;
  assign busy          = (count_q != '0) || (wr_en_q != '0);

endmodule

// File: tb/tb_cbus_writeback.sv
// Scoreboard bench for cbus_writeback: directed stimulus feeds a FIFO model,
// and a negedge monitor compares every C-bus write against the expected queue.
module tb_cbus_writeback;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 6;
  localparam int IDX_W    = 3;
  localparam int DEPTH    = 4;

  typedef struct {
    logic [NUM_REGS-1:0] wr_en;
    logic [DATA_W-1:0]   data;
    logic                bad;
  } exp_t;

  typedef struct {
    logic [IDX_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           stall;
  logic           flush;
  logic           bad_dest;
  logic [IDX_W:0] count;
  logic           busy;

  exp_t exp_q[$];
  ent_t mdl_q[$];
  exp_t mon_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   max_count = 0;

  cbus_writeback_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) bus_if ();

  cbus_writeback #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if.slave),
    .stall    (stall),
    .flush    (flush),
    .bad_dest (bad_dest),
    .count    (count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic drive_cycle(input logic v, input logic [IDX_W-1:0] d,
                             input logic [DATA_W-1:0] dat, input logic st, input logic fl);
    logic acc, pp;
    ent_t h;
    exp_t e;
    bus_if.req_valid = v;
    bus_if.req_dest  = d;
    bus_if.req_data  = dat;
    stall            = st;
    flush            = fl;
    @(negedge clk);
    check("count", 32'(count), 32'(mdl_q.size()));
    check("req_ready", 32'(bus_if.req_ready), 32'((mdl_q.size() < DEPTH) && !fl));
    if (int'(count) > max_count) max_count = int'(count);
    acc = v && (mdl_q.size() < DEPTH) && !fl;
    pp  = (mdl_q.size() != 0) && !st && !fl;
    if (fl) begin
      mdl_q.delete();
    end else begin
      if (pp) begin
        h      = mdl_q.pop_front();
        e.bad  = int'(h.dest) >= NUM_REGS;
        e.wr_en = e.bad ? '0 : (NUM_REGS'(1) << h.dest);
        e.data = h.data;
        exp_q.push_back(e);
      end
      if (acc) mdl_q.push_back('{dest: d, data: dat});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every visible write or bad-dest pulse consumes one expectation.
  always @(negedge clk) begin
    if (!rst && ((bus_if.wr_en != '0) || bad_dest)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {25'(bus_if.wr_en), 7'(bad_dest)}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_wr_en", 32'(bus_if.wr_en), 32'(mon_e.wr_en));
        check("mon_c_out", 32'(bus_if.c_out), 32'(mon_e.data));
        check("mon_bad_dest", 32'(bad_dest), 32'(mon_e.bad));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    stall            = 1'b0;
    flush            = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_dest  = '0;
    bus_if.req_data  = '0;
    #1;
    check("rst_wr_en", 32'(bus_if.wr_en), 32'd0);
    check("rst_c_out", 32'(bus_if.c_out), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_bad_dest", 32'(bad_dest), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single write: one cycle of wr_en one edge after acceptance.
    drive_cycle(1'b1, 3'd2, 16'hA5A5, 1'b0, 1'b0);
    check("t1_wr_en_early", 32'(bus_if.wr_en), 32'd0);
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check("t1_wr_en", 32'(bus_if.wr_en), 32'b000100);
    check("t1_c_out", 32'(bus_if.c_out), 32'hA5A5);
    check("t1_busy", 32'(busy), 32'd1);
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check("t1_wr_en_off", 32'(bus_if.wr_en), 32'd0);
    check("t1_busy_off", 32'(busy), 32'd0);
    check("t1_c_out_hold", 32'(bus_if.c_out), 32'hA5A5);

    // Back-to-back: push and pop overlap, occupancy stays at 1.
    max_count = 0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, IDX_W'(i), 16'(16'h0010 + i), 1'b0, 1'b0);
    idle(3);
    check("t2_max_count", 32'(max_count), 32'd1);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Full under stall, 5th held, accepted once count drops to 3.
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, IDX_W'(i), 16'(16'h0100 + i), 1'b1, 1'b0);
    repeat (2) drive_cycle(1'b1, 3'd5, 16'h0104, 1'b1, 1'b0);
    check("t3_full_count", 32'(count), 32'd4);
    check("t3_full_ready", 32'(bus_if.req_ready), 32'd0);
    drive_cycle(1'b1, 3'd5, 16'h0104, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd5, 16'h0104, 1'b0, 1'b0);
    idle(6);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Bad destinations (7 and the boundary 6) interleaved with a good one.
    drive_cycle(1'b1, 3'd7, 16'h1234, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd1, 16'h0AA1, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd6, 16'h0BB6, 1'b0, 1'b0);
    idle(4);
    check("t4_c_out_last", 32'(bus_if.c_out), 32'h0BB6);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Flush discards queued entries and refuses the same-cycle request.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, IDX_W'(i), 16'(16'h0200 + i), 1'b1, 1'b0);
    drive_cycle(1'b1, 3'd3, 16'h0233, 1'b1, 1'b1);
    check("t5_count", 32'(count), 32'd0);
    idle(4);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Async reset mid-drain.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, IDX_W'(i), 16'(16'h0300 + i), 1'b1, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check("t6_first_write", 32'(bus_if.wr_en), 32'b000001);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_wr_en", 32'(bus_if.wr_en), 32'd0);
    check("t6_rst_c_out", 32'(bus_if.c_out), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    mdl_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    check("t6_hold_wr_en", 32'(bus_if.wr_en), 32'd0);
    check("t6_hold_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(5);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
